button_capture: RTL and testbench

Front-end stage of the button-control register file. It synchronises and debounces the board push-buttons and packs the debounced levels and press/release events into a 32-bit status word. On every debounced change it issues a single-cycle system write, which lands in register 0 of the control register bank through that bank's `we_system` / `wr_data_system` port. Software and the game logic read register 0 to track button state, and use its sequence field to detect missed updates.

---
 rtl/button_capture.sv | 118 +++++++++++
 tb/tb_button_capture.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/button_capture.sv
`default_nettype none
// ============================================================================
// Module      : button_capture
// Description : Synchronises and debounces push-buttons, then emits one
//               status-word system write per debounced change.
// Revision    : 1.0 - initial release
// ============================================================================
module button_capture #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] btn_in,
    output logic [N_BUTTONS-1:0] pressed,
    output logic                 we_system,
    output logic [31:0]          wr_data_system
);

    localparam int                   c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0]   c_cnt_max  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BUTTONS-1:0] c_released = {N_BUTTONS{ACTIVE_LOW}};

    logic [N_BUTTONS-1:0] r_sync1;
    logic [N_BUTTONS-1:0] r_sync2;
    logic [N_BUTTONS-1:0] w_level;
    logic [N_BUTTONS-1:0] w_commit;
    logic [c_cnt_w-1:0]   r_cnt [N_BUTTONS];
    logic                 r_any;
    logic [N_BUTTONS-1:0] r_rise;
    logic [N_BUTTONS-1:0] r_fall;
    logic [7:0]           r_seq;
    logic [7:0]           w_seq_next;
    logic [7:0]           w_lvl8;
    logic [7:0]           w_rise8;
    logic [7:0]           w_fall8;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= c_released;
            r_sync2 <= c_released;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise so that 1 always means "pressed".
    assign w_level = r_sync2 ^ c_released;

    generate
        for (genvar g = 0; g < N_BUTTONS; g++) begin : g_commit
            assign w_commit[g] = (w_level[g] != pressed[g]) && (r_cnt[g] == c_cnt_max);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                r_cnt[i] <= '0;
            end
            pressed <= '0;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (w_level[i] == pressed[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_commit[i]) begin
                    pressed[i] <= w_level[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_w'(1);
                end
            end
        end
    end

    // Event capture lands alongside the updated levels, so the write stage
    // sees post-commit levels and the events of that same commit together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_any  <= 1'b0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_any  <= |w_commit;
            r_rise <= w_commit & w_level;
            r_fall <= w_commit & ~w_level;
        end
    end

    always_comb begin
        w_lvl8                   = '0;
        w_rise8                  = '0;
        w_fall8                  = '0;
        w_lvl8[N_BUTTONS-1:0]    = pressed;
        w_rise8[N_BUTTONS-1:0]   = r_rise;
        w_fall8[N_BUTTONS-1:0]   = r_fall;
    end

    assign w_seq_next = r_seq + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seq          <= '0;
            we_system      <= 1'b0;
            wr_data_system <= '0;
        end else begin
            we_system <= r_any;
            if (r_any) begin
                r_seq          <= w_seq_next;
                wr_data_system <= {w_seq_next, w_fall8, w_rise8, w_lvl8};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_capture
// Description : Directed self-checking bench for button_capture (D = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  btn_in;
    logic [3:0]  pressed;
    logic        we_system;
    logic [31:0] wr_data_system;

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          wr_idx = 0;
    logic [31:0] w256 = '0;
    logic [31:0] w257 = '0;

    button_capture #(
        .N_BUTTONS      (4),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_in        (btn_in),
        .pressed       (pressed),
        .we_system     (we_system),
        .wr_data_system(wr_data_system)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: total writes, plus per-reset write index for the wrap test.
    always @(posedge clk) begin
        if (we_system) wr_count <= wr_count + 1;
        if (!rst_n) begin
            wr_idx <= 0;
        end else if (we_system) begin
            wr_idx <= wr_idx + 1;
            if (wr_idx == 255) w256 <= wr_data_system;
            if (wr_idx == 256) w257 <= wr_data_system;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        btn_in = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Waits (bounded) for a write strobe sampled #1 after a rising edge.
    task automatic wait_write(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!we_system && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_strobe"}, {31'd0, we_system}, 32'd1);
        chk(tag, wr_data_system, exp);
    endtask

    initial begin
        int base;
        rst_n  = 1'b0;
        btn_in = 4'b1111;

        // 1. Reset state and quiet period
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pressed", {28'd0, pressed}, 32'd0);
        chk("rst_we", {31'd0, we_system}, 32'd0);
        chk("rst_data", wr_data_system, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = wr_count;
        repeat (20) @(negedge clk);
        chk("idle_no_write", wr_count - base, 32'd0);

        // 2. Single press with exact latency, then release
        @(negedge clk);
        btn_in[0] = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            chk($sformatf("press_we_e%0d", e), {31'd0, we_system}, (e == 6) ? 32'd1 : 32'd0);
            if (e == 4) chk("press_lvl_e4", {28'd0, pressed}, 32'd0);
            if (e == 5) chk("press_lvl_e5", {28'd0, pressed}, 32'd1);
            if (e == 6) chk("press_data", wr_data_system, 32'h0100_0101);
        end
        chk("hold_data", wr_data_system, 32'h0100_0101);
        @(negedge clk);
        btn_in[0] = 1'b1;
        wait_write("release_data", 32'h0201_0000);
        chk("release_lvl", {28'd0, pressed}, 32'd0);
        @(posedge clk); #1;
        chk("release_we_single", {31'd0, we_system}, 32'd0);

        // 3. Three-cycle glitch is rejected
        base = wr_count;
        @(negedge clk);
        btn_in[2] = 1'b0;
        repeat (3) @(negedge clk);
        btn_in[2] = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_no_write", wr_count - base, 32'd0);
        chk("glitch_lvl", {28'd0, pressed}, 32'd0);

        // 4. Simultaneous commit merges into one write
        do_reset();
        base = wr_count;
        @(negedge clk);
        btn_in = 4'b0101;
        wait_write("simul_data", 32'h0100_0A0A);
        repeat (10) @(negedge clk);
        chk("simul_one_write", wr_count - base, 32'd1);
        chk("simul_lvl", {28'd0, pressed}, 32'h0A);

        // 5. Back-to-back commits
        do_reset();
        @(negedge clk);
        btn_in = 4'b1101;
        @(negedge clk);
        btn_in = 4'b0101;
        wait_write("b2b_first", 32'h0100_0202);
        @(posedge clk); #1;
        chk("b2b_second_we", {31'd0, we_system}, 32'd1);
        chk("b2b_second", wr_data_system, 32'h0200_080A);
        @(posedge clk); #1;
        chk("b2b_end_we", {31'd0, we_system}, 32'd0);

        // 6a. Sequence wrap over 512 writes
        do_reset();
        for (int k = 0; k < 256; k++) begin
            btn_in[0] = 1'b0;
            repeat (10) @(negedge clk);
            btn_in[0] = 1'b1;
            repeat (10) @(negedge clk);
        end
        chk("wrap_count", wr_idx, 32'd512);
        chk("wrap_w256", w256, 32'h0001_0000);
        chk("wrap_w257", w257, 32'h0100_0101);
        chk("wrap_w512_live", wr_data_system, 32'h0001_0000);

        // 6b. Reset two cycles into a debounce, button held through it
        btn_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        base = wr_count;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_data", wr_data_system, 32'd0);
        chk("midrst_lvl", {28'd0, pressed}, 32'd0);
        rst_n = 1'b1;
        chk("midrst_no_write", wr_count - base, 32'd0);
        wait_write("midrst_fresh", 32'h0100_0101);
        chk("midrst_fresh_lvl", {28'd0, pressed}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
